// File: rtl/alu32_seq.sv
// Nibble-serial WIDTH-bit ALU: one 4-bit slice per clock, LSB first, carry chained.
// Optional ALU32_SEQ_ABORT_EN adds an abort input that cancels an in-flight op.

module alu32_seq_nib (
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] r,
    output logic       cout
);
    logic [4:0] s;

    always_comb begin
        s    = '0;
        r    = '0;
        cout = 1'b0;
        case (op)
            3'b000: r = ~a;
            3'b001: r = ~b;
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = ~(a ^ b);
            3'b110: begin
                s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                r    = s[3:0];
                cout = s[4];
            end
            default: begin
                s    = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
                r    = s[3:0];
                cout = s[4];
            end
        endcase
    end
endmodule

module alu32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef ALU32_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_d;

    logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nxt;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry, a_msb, b_msb;
    logic             load, last, abort_i, v_nxt;
    logic [3:0]       nib_r;
    logic             nib_cout;

`ifdef ALU32_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    alu32_seq_nib u_nib (
        .op   (op_q),
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry),
        .r    (nib_r),
        .cout (nib_cout)
    );

    assign last    = (cnt == CW'(NSLICE - 1));
    assign acc_nxt = {nib_r, acc[WIDTH-1:4]};
    assign busy    = (state == BUSY);
    assign done    = (state == DONE);

    // Overflow only needs the operand MSBs captured at start and the top result bit.
    always_comb begin
        v_nxt = 1'b0;
        if (op_q == 3'b110)
            v_nxt = (a_msb == b_msb) && (nib_r[3] != a_msb);
        else if (op_q == 3'b111)
            v_nxt = (a_msb != b_msb) && (nib_r[3] != a_msb);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (abort_i)   state_d = IDLE;
                else if (last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            op_q   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            result <= '0;
            c      <= 1'b0;
            n      <= 1'b0;
            z      <= 1'b0;
            v      <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            op_q  <= op;
            acc   <= '0;
            cnt   <= '0;
            carry <= (op == 3'b111);
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == BUSY) begin
            a_sr  <= a_sr >> 4;
            b_sr  <= b_sr >> 4;
            acc   <= acc_nxt;
            cnt   <= cnt + CW'(1);
            carry <= nib_cout;
            if (last && !abort_i) begin
                result <= acc_nxt;
                c      <= nib_cout;
                n      <= acc_nxt[WIDTH-1];
                z      <= (acc_nxt == '0);
                v      <= v_nxt;
            end
        end
    end
endmodule
